scene_palette_engine: RTL
=========================

SCENE_PALETTE_ENGINE -- requirements
Module: scene_palette_engine

Interface
REQ-001 Parameter IDX_W, default 4, width of colour index; palette depth is 2**IDX_W entries.
REQ-002 Parameter CH_W, default 4, width of each of red/green/blue.
REQ-003 Parameter FADE_W, default 4, width of brightness level; full brightness is 2**FADE_W-1.
REQ-004 Parameter TRANSP_EN, default 1, enables transparent flag for index 0.
REQ-005 Clk  in  1  the single clock; all state rising-edge triggered.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 pix_valid  in  1  lookup request this cycle.
REQ-008 pix_index  in  IDX_W  palette index to look up.
REQ-009 frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-010 wr_en  in  1  write one entry of the shadow bank.
REQ-011 wr_addr  in  IDX_W  shadow entry address.
REQ-012 wr_data  in  3*CH_W  {red,green,blue} for written entry.
REQ-013 swap_req  in  1  request shadow/active bank exchange at next frame_start.
REQ-014 fade_start  in  1  latch fade_target and begin fading.
REQ-015 fade_target  in  FADE_W  brightness to fade toward.
REQ-016 out_valid  out  1  red/green/blue/transparent valid.
REQ-017 red, green, blue  out  CH_W each  scaled colour.
REQ-018 transparent  out  1  looked-up index was 0 and TRANSP_EN=1.
REQ-019 swap_pending  out  1  swap requested, not yet performed.
REQ-020 fade_busy  out  1  fade state machine in FADING.

Function
REQ-021 Two register banks of 2**IDX_W entries; active_bank bit selects bank read by lookups; the other is shadow.
REQ-022 Writes always go to shadow bank; active bank never written; write takes effect next cycle.
REQ-023 Lookup pipeline, latency 2: cycle N pix_valid/pix_index -> cycle N+1 entry and index registered -> cycle N+2 out_valid=1 with scaled colour; fully pipelined, one lookup per cycle, no stalls.
REQ-024 Scaling per channel: out = (entry_ch * (bright+1)) >> FADE_W, intermediate width CH_W+FADE_W+1, result truncated to CH_W; bright=max returns entry_ch exactly, bright=0 returns entry_ch>>FADE_W.
REQ-025 bright and active_bank used for scaling/selection are the values current in the cycle the lookup enters stage 1.
REQ-026 swap_req sets swap_pending; on frame_start with swap_pending=1 (including swap_req in the same cycle) active_bank toggles and swap_pending clears; swap_req while pending has no further effect.
REQ-027 wr_en in the same cycle as a swap writes the pre-swap shadow bank (which becomes active).
REQ-028 Fade FSM states IDLE, FADING; fade_start latches fade_target and enters FADING (also retargets if already FADING).
REQ-029 In FADING, each frame_start moves bright one step toward target; when bright equals target after the step (or at fade_start), return to IDLE.
REQ-030 fade_start with target equal to current bright: stays/returns IDLE, bright unchanged.
REQ-031 fade_start coincident with frame_start: latch target this cycle, first step at the next frame_start.
REQ-032 bright never changes except on frame_start, so no mid-frame brightness change.

Reset
REQ-033 Reset asserts asynchronously: out_valid=0, red/green/blue=0, transparent=0, swap_pending=0, fade_busy=0, FSM=IDLE, active_bank=0, bright=2**FADE_W-1, pipeline valids cleared.
REQ-034 Reset loads both banks with grey ramp: entry i = {i,i,i} truncated/zero-extended to CH_W.
REQ-035 Reset mid-fade or mid-pending-swap abandons the operation; no output pulse after deassertion until a new pix_valid.

Verification
REQ-036 After reset, pix_valid with index 5 at cycle N -> cycle N+2 out_valid=1, rgb={5,5,5}, transparent=0; index 0 -> rgb={0,0,0}, transparent=1.
REQ-037 Write wr_addr=3, wr_data=12'hE84, then lookup 3 -> still {3,3,3}; swap_req, frame_start, lookup 3 -> {E,8,4}, swap_pending low after frame_start.
REQ-038 Back-to-back lookups indices 1,2,...,15 on consecutive cycles -> 15 consecutive out_valid cycles, values in order, none dropped.
REQ-039 fade_start target 0 -> fade_busy=1; after k frame_starts bright=15-k; entry {F,F,F} after 8 frames gives {7,7,7}; after 15 frames fade_busy=0, output {0,0,0}.
REQ-040 swap_req and wr_en both coincident with frame_start -> written entry visible in active bank next cycle; fade_start coincident with frame_start -> bright unchanged that cycle.
REQ-041 Reset asserted mid-fade (bright=9) with swap_pending=1 -> immediately bright=15, fade_busy=0, swap_pending=0, active_bank=0, banks restored to grey ramp.

Source files
------------

// File: rtl/scene_palette_engine.sv
// Palette lookup engine. It has double-buffered colour banks, a bank swap timed
// to the frame boundary, and a brightness fade that steps once per frame.
// Latency is 2 cycles from pix_valid to out_valid. The pipeline is fully
// pipelined and never applies backpressure: it accepts one lookup per cycle.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   pix_valid, pix_index      lookup request
//   frame_start               vertical-blank pulse; paces swaps and fade steps
//   wr_en, wr_addr, wr_data   write one entry of the shadow bank ({r,g,b})
//   swap_req                  exchange banks at the next frame_start
//   fade_start, fade_target   begin fading brightness toward fade_target
//   out_valid, red, green, blue, transparent   scaled lookup result
//   swap_pending, fade_busy   status
module scene_palette_engine #(
    parameter int IDX_W     = 4,
    parameter int CH_W      = 4,
    parameter int FADE_W    = 4,
    parameter bit TRANSP_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    input  logic [IDX_W-1:0]    pix_index,
    input  logic                frame_start,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                swap_req,
    input  logic                fade_start,
    input  logic [FADE_W-1:0]   fade_target,
    output logic                out_valid,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                transparent,
    output logic                swap_pending,
    output logic                fade_busy
);

    localparam int DEPTH  = 1 << IDX_W;
    localparam int ENT_W  = 3 * CH_W;
    localparam int PROD_W = CH_W + FADE_W + 1;

    typedef enum logic {IDLE, FADING} fade_state_t;

    logic [ENT_W-1:0]  bank0 [DEPTH];
    logic [ENT_W-1:0]  bank1 [DEPTH];
    logic              active_bank;

    fade_state_t       state;
    logic [FADE_W-1:0] bright;
    logic [FADE_W-1:0] target;
    logic [FADE_W-1:0] bright_step;

    logic              s1_valid;
    logic [ENT_W-1:0]  s1_entry;
    logic              s1_zero;
    logic [FADE_W-1:0] s1_bright;
    logic [ENT_W-1:0]  rd_entry;

    // Grey ramp reset value: every channel of entry i equals i.
    function automatic logic [ENT_W-1:0] grey(input int i);
        logic [CH_W-1:0] c;
        c = CH_W'(i);
        return {c, c, c};
    endfunction

    // Scaled channel: (ch * (b+1)) >> FADE_W. Full brightness passes ch through unchanged.
    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] ch,
                                              input logic [FADE_W-1:0] b);
        logic [FADE_W:0]   mult;
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] shifted;
        mult    = {1'b0, b} + (FADE_W+1)'(1);
        prod    = PROD_W'(ch) * PROD_W'(mult);
        shifted = prod >> FADE_W;
        return shifted[CH_W-1:0];
    endfunction

    // Palette banks. Writes always target the bank that is currently not active.
    // When a write coincides with a swap, it lands in the bank that becomes active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank0[i] <= grey(i);
                bank1[i] <= grey(i);
            end
        end else if (wr_en) begin
            if (active_bank)
                bank0[wr_addr] <= wr_data;
            else
                bank1[wr_addr] <= wr_data;
        end
    end

    // Bank swap control. The swap only ever happens on a frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
        end else if (frame_start && (swap_pending || swap_req)) begin
            active_bank  <= ~active_bank;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    always_comb begin
        bright_step = bright;
        if (bright > target)
            bright_step = bright - FADE_W'(1);
        else if (bright < target)
            bright_step = bright + FADE_W'(1);
    end

    // Fade FSM. A fade_start on a frame boundary only latches the target, so
    // brightness is never changed in the same cycle as a (re)target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bright    <= '1;
            target    <= '1;
            fade_busy <= 1'b0;
        end else if (fade_start) begin
            target <= fade_target;
            if (fade_target == bright) begin
                state     <= IDLE;
                fade_busy <= 1'b0;
            end else begin
                state     <= FADING;
                fade_busy <= 1'b1;
            end
        end else if (state == FADING && frame_start) begin
            bright <= bright_step;
            if (bright_step == target) begin
                state     <= IDLE;
                fade_busy <= 1'b0;
            end
        end
    end

    assign rd_entry = active_bank ? bank1[pix_index] : bank0[pix_index];

    // Stage 1 captures the entry, and the brightness in force, when the request arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_entry  <= '0;
            s1_zero   <= 1'b0;
            s1_bright <= '0;
        end else begin
            s1_valid  <= pix_valid;
            s1_entry  <= rd_entry;
            s1_zero   <= (pix_index == '0);
            s1_bright <= bright;
        end
    end

    // Stage 2: scale and register the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                red         <= scale(s1_entry[3*CH_W-1:2*CH_W], s1_bright);
                green       <= scale(s1_entry[2*CH_W-1:CH_W], s1_bright);
                blue        <= scale(s1_entry[CH_W-1:0], s1_bright);
                transparent <= TRANSP_EN && s1_zero;
            end
        end
    end

endmodule
